postfix_evaluator: RTL and testbench
====================================

POSTFIX_EVALUATOR -- requirements
Module: postfix_evaluator

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter DEPTH, default 16, SHALL set the operand stack depth in 16-bit entries.
REQ-003 Sysclk  in  1  system clock; all logic SHALL update on its rising edge.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 Token  in  8  postfix token; its encoding SHALL be as defined in REQ-011.
REQ-006 Tok_Valid  in  1  SHALL be high when Token holds a valid token.
REQ-007 Tok_Ready  out  1  SHALL be high when the block can accept a token; a token SHALL be accepted on an edge where Tok_Valid and Tok_Ready are both high.
REQ-008 Result  out  16  final value of the expression.
REQ-009 Finish  out  1  SHALL be high when the evaluation completed successfully.
REQ-010 Fault  out  1  SHALL be high when the evaluation was aborted with an error.

Function
REQ-011 Token encoding SHALL be: 8'h30-8'h39 operand of value Token-8'h30; 8'h2B add; 8'h2D subtract; 8'h2A multiply; 8'h2F divide; 8'h00 end of expression; any other value illegal.
REQ-012 FSM states SHALL be FETCH, EXEC, DIV, DONE and ERROR; FETCH SHALL be entered on reset.
REQ-013 Tok_Ready SHALL be 1 only in FETCH.
REQ-014 Operand accepted in FETCH with stack pointer sp<DEPTH: the value SHALL be pushed zero-extended to 16 bits, sp+1, and the FSM SHALL stay in FETCH (one token per cycle).
REQ-015 Operator accepted in FETCH with sp<2 (underflow): next state SHALL be ERROR.
REQ-016 Operand accepted with sp==DEPTH (overflow): next state SHALL be ERROR.
REQ-017 Illegal token accepted: next state SHALL be ERROR.
REQ-018 Operator accepted with sp>=2: the operator SHALL be latched and the next state SHALL be EXEC.
REQ-019 Operands SHALL be A = stack[sp-2] (pushed earlier) and B = stack[sp-1] (top).
REQ-020 EXEC with add, subtract or multiply:
 - stack[sp-2] SHALL receive A+B, A-B or the low 16 bits of A*B, unsigned, wrapping modulo 2^16;
 - sp SHALL decrement by 1;
 - the FSM SHALL return to FETCH.
 Tok_Ready SHALL be low for exactly 1 cycle after the operator is accepted.
REQ-021 EXEC with divide and B==0: the FSM SHALL go to ERROR, with no stack write and no DIV cycles.
REQ-022 EXEC with divide and B!=0: the FSM SHALL enter DIV.
 - DIV SHALL run a restoring unsigned divider for exactly 16 cycles, one quotient bit per cycle.
 - On the 16th cycle floor(A/B) SHALL be written to stack[sp-2], sp-1, and the FSM SHALL return to FETCH.
 - Tok_Ready SHALL be low for 17 cycles after the divide is accepted.
REQ-023 Terminator accepted:
 - sp==1: Result SHALL take stack[0] and Finish SHALL go high on the next edge; next state DONE.
 - sp!=1: next state SHALL be ERROR.
REQ-024 DONE SHALL hold Result and Finish=1 until Rst; it SHALL ignore Tok_Valid.
REQ-025 ERROR SHALL hold Fault=1 and Result=0 until Rst; it SHALL ignore Tok_Valid.
REQ-026 Finish and Fault SHALL never be high at the same time.
REQ-027 Stack contents above sp SHALL be don't-care and SHALL NOT affect any output.

Reset
REQ-028 When Rst is high at an edge:
 - state SHALL be FETCH and sp SHALL be 0;
 - Result SHALL be 0, Finish 0, Fault 0 and Tok_Ready 1 after that edge;
 - any divide in progress SHALL be abandoned.
REQ-029 Reset SHALL take priority over a token accepted in the same cycle; that token SHALL be discarded.

Verification
REQ-030 Tokens "3","4","+",00 sent back-to-back -> Tok_Ready low 1 cycle after "+"; Result=16'd7; Finish=1 one cycle after 00 is accepted; Fault=0.
REQ-031 Tokens "9","3","-","2","*",00 -> Result=16'd12; "0","1","-",00 -> Result=16'hFFFF (wrap).
REQ-032 Tokens "7","2","/",00 -> Tok_Ready low exactly 17 cycles after "/"; Result=16'd3.
REQ-033 Fault cases, each -> Fault=1, Result=0, Finish=0:
 - "5","0","/" -> Fault one cycle after EXEC;
 - "+" as the first token -> Fault on the next cycle;
 - DEPTH+1 operands -> Fault;
 - token 8'h41 -> Fault;
 - "1","2",00 -> Fault.
REQ-034 Rst asserted during the 8th DIV cycle -> next cycle: Tok_Ready=1, sp=0, Finish=0, Fault=0; then "8","4","/",00 -> Result=16'd2.

Source files
------------

// File: rtl/postfix_evaluator.sv
// postfix_evaluator: evaluates a stream of postfix tokens (single-digit
// operands, + - * /, 0x00 terminator) on a 16-bit operand stack. Add, subtract
// and multiply take one execute cycle. Divide runs a 16-cycle restoring
// divider. Any stack underflow or overflow, illegal token, divide by zero or
// malformed terminator latches the block in ERROR until Rst.
// DEPTH must be a power of two and at least 2.
module postfix_evaluator #(
  parameter int DEPTH = 16
) (
  input  logic        Sysclk,
  input  logic        Rst,
  input  logic [7:0]  Token,
  input  logic        Tok_Valid,
  output logic        Tok_Ready,
  output logic [15:0] Result,
  output logic        Finish,
  output logic        Fault
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    DIV   = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  state_t          state_r;
  state_t          state_n_s;
  op_t             op_r;
  op_t             tok_op_s;
  logic [SPW-1:0]  sp_r;
  logic [15:0]     stack_r [0:DEPTH-1];

  // Divider state: dividend shifts out of quo_r while quotient bits shift in.
  logic [15:0]     rem_r;
  logic [15:0]     quo_r;
  logic [15:0]     dvsr_r;
  logic [3:0]      cnt_r;

  logic            ready_r;
  logic [15:0]     result_r;
  logic            finish_r;
  logic            fault_r;

  logic            accept_s;
  logic            is_num_s;
  logic            is_op_s;
  logic            is_end_s;
  logic [15:0]     tok_val_s;
  logic [IW-1:0]   idx_push_s;
  logic [IW-1:0]   idx_m1_s;
  logic [IW-1:0]   idx_m2_s;
  logic [15:0]     a_s;
  logic [15:0]     b_s;
  logic [15:0]     alu_s;
  logic [16:0]     rem_sh_s;
  logic [16:0]     trial_s;
  logic [15:0]     rem_nx_s;
  logic [15:0]     quo_nx_s;

  logic            do_push_s;
  logic            do_latch_op_s;
  logic            do_alu_s;
  logic            do_div_start_s;
  logic            do_div_step_s;
  logic            do_div_end_s;
  logic            do_done_s;

  assign Tok_Ready = ready_r;
  assign Result    = result_r;
  assign Finish    = finish_r;
  assign Fault     = fault_r;

  // Token decode, operand fetch, ALU and one restoring-divider step.
  always_comb begin
    accept_s   = (state_r == FETCH) && Tok_Valid;
    is_num_s   = (Token >= 8'h30) && (Token <= 8'h39);
    is_end_s   = (Token == 8'h00);
    is_op_s    = 1'b1;
    tok_op_s   = OP_ADD;
    case (Token)
      8'h2B:   tok_op_s = OP_ADD;
      8'h2D:   tok_op_s = OP_SUB;
      8'h2A:   tok_op_s = OP_MUL;
      8'h2F:   tok_op_s = OP_DIV;
      default: is_op_s  = 1'b0;
    endcase
    // Digits 0x30..0x39 carry their value in the low nibble.
    tok_val_s  = {12'h000, Token[3:0]};
    idx_push_s = IW'(sp_r);
    idx_m1_s   = IW'(sp_r - SPW'(1));
    idx_m2_s   = IW'(sp_r - SPW'(2));
    a_s        = stack_r[idx_m2_s];
    b_s        = stack_r[idx_m1_s];
    case (op_r)
      OP_ADD:  alu_s = a_s + b_s;
      OP_SUB:  alu_s = a_s - b_s;
      OP_MUL:  alu_s = a_s * b_s;
      default: alu_s = 16'h0000;
    endcase
    rem_sh_s = {rem_r, quo_r[15]};
    trial_s  = rem_sh_s - {1'b0, dvsr_r};
    if (trial_s[16] == 1'b0) begin
      rem_nx_s = trial_s[15:0];
      quo_nx_s = {quo_r[14:0], 1'b1};
    end else begin
      rem_nx_s = rem_sh_s[15:0];
      quo_nx_s = {quo_r[14:0], 1'b0};
    end
  end

  // Next-state and datapath action decode.
  always_comb begin
    state_n_s      = state_r;
    do_push_s      = 1'b0;
    do_latch_op_s  = 1'b0;
    do_alu_s       = 1'b0;
    do_div_start_s = 1'b0;
    do_div_step_s  = 1'b0;
    do_div_end_s   = 1'b0;
    do_done_s      = 1'b0;
    case (state_r)
      FETCH: begin
        if (accept_s) begin
          if (is_num_s) begin
            if (sp_r < SPW'(DEPTH)) begin
              do_push_s = 1'b1;
              state_n_s = FETCH;
            end else begin
              state_n_s = ERROR;
            end
          end else if (is_op_s) begin
            if (sp_r >= SPW'(2)) begin
              do_latch_op_s = 1'b1;
              state_n_s     = EXEC;
            end else begin
              state_n_s = ERROR;
            end
          end else if (is_end_s) begin
            if (sp_r == SPW'(1)) begin
              do_done_s = 1'b1;
              state_n_s = DONE;
            end else begin
              state_n_s = ERROR;
            end
          end else begin
            state_n_s = ERROR;
          end
        end else begin
          state_n_s = FETCH;
        end
      end
      EXEC: begin
        if (op_r == OP_DIV) begin
          if (b_s == 16'h0000) begin
            state_n_s = ERROR;
          end else begin
            do_div_start_s = 1'b1;
            state_n_s      = DIV;
          end
        end else begin
          do_alu_s  = 1'b1;
          state_n_s = FETCH;
        end
      end
      DIV: begin
        do_div_step_s = 1'b1;
        if (cnt_r == 4'd15) begin
          do_div_end_s = 1'b1;
          state_n_s    = FETCH;
        end else begin
          state_n_s = DIV;
        end
      end
      DONE:    state_n_s = DONE;
      ERROR:   state_n_s = ERROR;
      default: state_n_s = ERROR;
    endcase
  end

  // State register.
  always_ff @(posedge Sysclk) begin
    if (Rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Stack pointer, operator latch, divider and registered outputs.
  always_ff @(posedge Sysclk) begin
    if (Rst) begin
      sp_r     <= '0;
      op_r     <= OP_ADD;
      rem_r    <= 16'h0000;
      quo_r    <= 16'h0000;
      dvsr_r   <= 16'h0000;
      cnt_r    <= 4'd0;
      ready_r  <= 1'b1;
      result_r <= 16'h0000;
      finish_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        sp_r <= sp_r + SPW'(1);
      end else if (do_alu_s || do_div_end_s) begin
        sp_r <= sp_r - SPW'(1);
      end
      if (do_latch_op_s) begin
        op_r <= tok_op_s;
      end
      if (do_div_start_s) begin
        quo_r  <= a_s;
        dvsr_r <= b_s;
        rem_r  <= 16'h0000;
        cnt_r  <= 4'd0;
      end else if (do_div_step_s) begin
        quo_r <= quo_nx_s;
        rem_r <= rem_nx_s;
        cnt_r <= cnt_r + 4'd1;
      end
      if (do_done_s) begin
        result_r <= stack_r[0];
      end
      ready_r  <= (state_n_s == FETCH);
      finish_r <= (state_n_s == DONE);
      fault_r  <= (state_n_s == ERROR);
    end
  end

  // Operand stack writes; contents are never cleared since entries at or
  // above sp are never read.
  always_ff @(posedge Sysclk) begin
    if (!Rst) begin
      if (do_push_s) begin
        stack_r[idx_push_s] <= tok_val_s;
      end else if (do_alu_s) begin
        stack_r[idx_m2_s] <= alu_s;
      end else if (do_div_end_s) begin
        stack_r[idx_m2_s] <= quo_nx_s;
      end
    end
  end

endmodule

// File: tb/tb_postfix_evaluator.sv
// Directed self-checking bench for postfix_evaluator.
module tb_postfix_evaluator;

  localparam int DEPTH = 16;

  logic        Sysclk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  Token = 8'h00;
  logic        Tok_Valid = 1'b0;
  logic        Tok_Ready;
  logic [15:0] Result;
  logic        Finish;
  logic        Fault;

  int checks = 0;
  int errors = 0;

  always #5 Sysclk = ~Sysclk;

  postfix_evaluator #(.DEPTH(DEPTH)) dut (
    .Sysclk    (Sysclk),
    .Rst       (Rst),
    .Token     (Token),
    .Tok_Valid (Tok_Valid),
    .Tok_Ready (Tok_Ready),
    .Result    (Result),
    .Finish    (Finish),
    .Fault     (Fault)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge Sysclk);
    Rst = 1'b1;
    Tok_Valid = 1'b0;
    Token = 8'h00;
    @(posedge Sysclk);
    #1;
    Rst = 1'b0;
  endtask

  // Presents a token at the falling edge once Tok_Ready is seen, returns 1ns after the accepting edge.
  task automatic send_tok(input logic [7:0] t);
    int w;
    w = 0;
    @(negedge Sysclk);
    while (Tok_Ready !== 1'b1 && w < 100) begin
      @(negedge Sysclk);
      w++;
    end
    if (w >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_tok: Tok_Ready never rose for token %0h", t);
    end
    Token = t;
    Tok_Valid = 1'b1;
    @(posedge Sysclk);
    #1;
    Tok_Valid = 1'b0;
  endtask

  // Counts cycles Tok_Ready stays low, starting 1ns after an accepting edge.
  task automatic count_busy(output int n);
    n = 0;
    while (Tok_Ready === 1'b0 && n < 60) begin
      @(posedge Sysclk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Tok_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", Tok_Ready); end
    checks++; if (Result !== 16'd0) begin errors++; $display("FAIL reset_result: got %0h expected 0", Result); end
    checks++; if (Finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", Finish); end
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", Fault); end
  endtask

  task automatic test_back_to_back_add();
    int n;
    do_reset();
    send_tok(8'h33);
    send_tok(8'h34);
    send_tok(8'h2B);
    count_busy(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL add_busy: got %0d cycles expected 1", n); end
    send_tok(8'h00);
    checks++; if (Finish !== 1'b1) begin errors++; $display("FAIL add_finish: got %b expected 1", Finish); end
    checks++; if (Result !== 16'd7) begin errors++; $display("FAIL add_result: got %0d expected 7", Result); end
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL add_fault: got %b expected 0", Fault); end
    checks++; if (Tok_Ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b expected 0", Tok_Ready); end
    // DONE must ignore further tokens.
    @(negedge Sysclk);
    Token = 8'h35;
    Tok_Valid = 1'b1;
    repeat (3) @(posedge Sysclk);
    #1;
    Tok_Valid = 1'b0;
    checks++; if (Result !== 16'd7 || Finish !== 1'b1 || Fault !== 1'b0) begin
      errors++; $display("FAIL done_hold: got result=%0d finish=%b fault=%b expected 7/1/0", Result, Finish, Fault);
    end
  endtask

  task automatic test_sub_mul();
    do_reset();
    send_tok(8'h39); send_tok(8'h33); send_tok(8'h2D);
    send_tok(8'h32); send_tok(8'h2A); send_tok(8'h00);
    checks++; if (Result !== 16'd12 || Finish !== 1'b1) begin
      errors++; $display("FAIL sub_mul: got result=%0d finish=%b expected 12/1", Result, Finish);
    end
    do_reset();
    send_tok(8'h30); send_tok(8'h31); send_tok(8'h2D); send_tok(8'h00);
    checks++; if (Result !== 16'hFFFF || Finish !== 1'b1) begin
      errors++; $display("FAIL sub_wrap: got result=%0h finish=%b expected ffff/1", Result, Finish);
    end
    // 9^6 = 531441, mod 65536 = 7153
    do_reset();
    send_tok(8'h39);
    for (int i = 0; i < 5; i++) begin
      send_tok(8'h39);
      send_tok(8'h2A);
    end
    send_tok(8'h00);
    checks++; if (Result !== 16'd7153 || Finish !== 1'b1) begin
      errors++; $display("FAIL mul_wrap: got result=%0d finish=%b expected 7153/1", Result, Finish);
    end
  endtask

  task automatic test_div();
    int n;
    do_reset();
    send_tok(8'h37); send_tok(8'h32); send_tok(8'h2F);
    count_busy(n);
    checks++; if (n !== 17) begin errors++; $display("FAIL div_busy: got %0d cycles expected 17", n); end
    send_tok(8'h00);
    checks++; if (Result !== 16'd3 || Finish !== 1'b1) begin
      errors++; $display("FAIL div_7_2: got result=%0d finish=%b expected 3/1", Result, Finish);
    end
    // 9^4 / 7 = 6561 / 7 = 937
    do_reset();
    send_tok(8'h39);
    for (int i = 0; i < 3; i++) begin
      send_tok(8'h39);
      send_tok(8'h2A);
    end
    send_tok(8'h37); send_tok(8'h2F); send_tok(8'h00);
    checks++; if (Result !== 16'd937 || Finish !== 1'b1) begin
      errors++; $display("FAIL div_6561_7: got result=%0d finish=%b expected 937/1", Result, Finish);
    end
  endtask

  task automatic test_faults();
    // divide by zero
    do_reset();
    send_tok(8'h35); send_tok(8'h30); send_tok(8'h2F);
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL div0_exec: got fault=%b expected 0", Fault); end
    @(posedge Sysclk); #1;
    checks++; if (Fault !== 1'b1 || Result !== 16'd0 || Finish !== 1'b0 || Tok_Ready !== 1'b0) begin
      errors++; $display("FAIL div0: got fault=%b result=%0h finish=%b ready=%b expected 1/0/0/0", Fault, Result, Finish, Tok_Ready);
    end
    @(negedge Sysclk);
    Token = 8'h00;
    Tok_Valid = 1'b1;
    repeat (3) @(posedge Sysclk);
    #1;
    Tok_Valid = 1'b0;
    checks++; if (Fault !== 1'b1 || Finish !== 1'b0) begin
      errors++; $display("FAIL error_hold: got fault=%b finish=%b expected 1/0", Fault, Finish);
    end
    // operator first
    do_reset();
    send_tok(8'h2B);
    checks++; if (Fault !== 1'b1 || Result !== 16'd0 || Finish !== 1'b0) begin
      errors++; $display("FAIL underflow: got fault=%b result=%0h finish=%b expected 1/0/0", Fault, Result, Finish);
    end
    // overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_tok(8'h31);
    checks++; if (Fault !== 1'b0 || Tok_Ready !== 1'b1) begin
      errors++; $display("FAIL full_stack: got fault=%b ready=%b expected 0/1", Fault, Tok_Ready);
    end
    send_tok(8'h31);
    checks++; if (Fault !== 1'b1 || Result !== 16'd0 || Finish !== 1'b0) begin
      errors++; $display("FAIL overflow: got fault=%b result=%0h finish=%b expected 1/0/0", Fault, Result, Finish);
    end
    // illegal token
    do_reset();
    send_tok(8'h41);
    checks++; if (Fault !== 1'b1 || Result !== 16'd0 || Finish !== 1'b0) begin
      errors++; $display("FAIL illegal: got fault=%b result=%0h finish=%b expected 1/0/0", Fault, Result, Finish);
    end
    // terminator with two entries on stack
    do_reset();
    send_tok(8'h31); send_tok(8'h32); send_tok(8'h00);
    checks++; if (Fault !== 1'b1 || Result !== 16'd0 || Finish !== 1'b0) begin
      errors++; $display("FAIL bad_end: got fault=%b result=%0h finish=%b expected 1/0/0", Fault, Result, Finish);
    end
  endtask

  task automatic test_reset_during_div();
    do_reset();
    send_tok(8'h39); send_tok(8'h33); send_tok(8'h2F);
    // After the accepting edge: EXEC, then DIV cycles. Hold Rst over the 8th DIV cycle.
    repeat (8) @(posedge Sysclk);
    #1;
    checks++; if (Tok_Ready !== 1'b0) begin errors++; $display("FAIL div_busy_mid: got ready=%b expected 0", Tok_Ready); end
    Rst = 1'b1;
    @(posedge Sysclk);
    #1;
    Rst = 1'b0;
    checks++; if (Tok_Ready !== 1'b1 || Finish !== 1'b0 || Fault !== 1'b0 || Result !== 16'd0) begin
      errors++; $display("FAIL div_abort: got ready=%b finish=%b fault=%b result=%0h expected 1/0/0/0", Tok_Ready, Finish, Fault, Result);
    end
    send_tok(8'h38); send_tok(8'h34); send_tok(8'h2F); send_tok(8'h00);
    checks++; if (Result !== 16'd2 || Finish !== 1'b1 || Fault !== 1'b0) begin
      errors++; $display("FAIL div_after_abort: got result=%0d finish=%b fault=%b expected 2/1/0", Result, Finish, Fault);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    // A token presented together with Rst must be dropped, leaving sp at 0.
    @(negedge Sysclk);
    Rst = 1'b1;
    Token = 8'h35;
    Tok_Valid = 1'b1;
    @(posedge Sysclk);
    #1;
    Rst = 1'b0;
    Tok_Valid = 1'b0;
    send_tok(8'h00);
    checks++; if (Fault !== 1'b1 || Finish !== 1'b0) begin
      errors++; $display("FAIL reset_priority: got fault=%b finish=%b expected 1/0", Fault, Finish);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back_add();
    test_sub_mul();
    test_div();
    test_faults();
    test_reset_during_div();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
